// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame constants and bit-timing helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int clocks_per_bit(input longint freq, input longint baud);
    return int'(freq / baud);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1 while enabled, pulses bit_end_o on the last count.
module uart_bit_timer #(
  parameter int CLOCKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || !en_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end_o = en_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_transmit.sv
// 8N1/8N2 UART transmitter: valid/ready byte input, registered idle-high serial output.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int STOP_BITS        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       busy,
  output logic       dout
);

  localparam int CLOCKS_PER_BIT = clocks_per_bit(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_transmit: CLOCKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_transmit: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t state_q;
  logic [7:0]     shift_q;
  logic [2:0]     idx_q;
  logic           stop_idx_q;
  logic           dout_q, busy_q;
  logic           xfer, bit_end;

  assign din_ready = (state_q == IDLE) && !rst;
  assign xfer      = din_valid && din_ready;
  assign busy      = busy_q;
  assign dout      = dout_q;

  uart_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != IDLE),
    .restart_i (xfer),
    .bit_end_o (bit_end)
  );

  // Line level is decided one cycle ahead so dout comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      dout_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (xfer) begin
          shift_q    <= din;
          idx_q      <= '0;
          stop_idx_q <= 1'b0;
          dout_q     <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= START;
        end
        START: if (bit_end) begin
          dout_q  <= shift_q[0];
          idx_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          if (idx_q == LAST_BIT) begin
            dout_q     <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= STOP;
          end else begin
            idx_q   <= idx_q + 3'd1;
            shift_q <= shift_q >> 1;
            dout_q  <= shift_q[1];
          end
        end
        STOP: if (bit_end) begin
          if (stop_idx_q == LAST_STOP) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            stop_idx_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: one STOP_BITS=1 and one STOP_BITS=2 instance checked against a line-level model.
module tb_uart_transmit;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic       r1, b1, d1, r2, b2, d2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uart_transmit #(.INPUT_CLOCK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(v1), .din_ready(r1), .busy(b1), .dout(d1));

  uart_transmit #(.INPUT_CLOCK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(v2), .din_ready(r2), .busy(b2), .dout(d2));

  // Expected line level k cycles into a frame: start bit, 8 data bits LSB first, then stop level.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int n;
    n = k / CPB;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    return 1'b1;
  endfunction

  // Sends one byte, optionally pulsing din_valid (0x3C) at frame offset inject_k, and checks every cycle.
  task automatic test_frame(input logic [7:0] b, input bit sel, input int inject_k, input string name);
    int f;
    f = (9 + (sel ? 2 : 1)) * CPB;
    @(negedge clk);
    vecs++;
    if ((sel ? r2 : r1) !== 1'b1) begin
      errs++; $display("FAIL %s ready_before_send got %b want 1", name, sel ? r2 : r1);
    end
    din = b;
    if (sel) v2 = 1'b1; else v1 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < f; k++) begin
      logic dd, bb, rr, ee;
      if (k == inject_k) begin
        din = 8'h3C;
        if (sel) v2 = 1'b1; else v1 = 1'b1;
      end else begin
        v1 = 1'b0; v2 = 1'b0;
        din = 8'($urandom);
      end
      dd = sel ? d2 : d1;
      bb = sel ? b2 : b1;
      rr = sel ? r2 : r1;
      ee = exp_line(b, k);
      vecs++;
      if (dd !== ee || bb !== 1'b1 || rr !== 1'b0) begin
        errs++;
        $display("FAIL %s byte=%h cycle=%0d got dout/busy/ready=%b%b%b want %b10", name, b, k, dd, bb, rr, ee);
      end
      @(negedge clk);
    end
    v1 = 1'b0; v2 = 1'b0;
    vecs++;
    if ((sel ? d2 : d1) !== 1'b1 || (sel ? b2 : b1) !== 1'b0 || (sel ? r2 : r1) !== 1'b1) begin
      errs++;
      $display("FAIL %s idle_after got dout/busy/ready=%b%b%b want 101", name,
               sel ? d2 : d1, sel ? b2 : b1, sel ? r2 : r1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vecs++;
      if (d1 !== 1'b1 || b1 !== 1'b0 || r1 !== 1'b0 || d2 !== 1'b1 || b2 !== 1'b0 || r2 !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold got d/b/r=%b%b%b %b%b%b want 100 100", d1, b1, r1, d2, b2, r2);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (d1 !== 1'b1 || b1 !== 1'b0 || r1 !== 1'b1 || d2 !== 1'b1 || b2 !== 1'b0 || r2 !== 1'b1) begin
      errs++;
      $display("FAIL reset_release got d/b/r=%b%b%b %b%b%b want 101 101", d1, b1, r1, d2, b2, r2);
    end
  endtask

  task automatic test_back_to_back();
    logic q[$];
    bit drop;
    int s1, s2;
    logic [7:0] by1, by2;
    drop = 1'b0; s1 = -1; s2 = -1;
    @(negedge clk);
    din = 8'h00; v1 = 1'b1;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      q.push_back(d1);
      if (c == 0) din = 8'hFF;
      if (drop) v1 = 1'b0;
      else if (c > 0 && r1) drop = 1'b1;
    end
    v1 = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == 1'b0 && (i == 0 || q[i-1] == 1'b1)) begin
        if (s1 < 0) s1 = i;
        else if (s2 < 0) s2 = i;
      end
    end
    vecs++;
    if (s1 < 0 || s2 < 0 || (s2 - s1) != (10 * CPB + 1)) begin
      errs++; $display("FAIL b2b_spacing got %0d want %0d", s2 - s1, 10 * CPB + 1);
    end else begin
      for (int i = 0; i < 8; i++) begin
        by1[i] = q[s1 + CPB * (i + 1) + CPB / 2];
        by2[i] = q[s2 + CPB * (i + 1) + CPB / 2];
      end
      vecs++;
      if (by1 !== 8'h00 || by2 !== 8'hFF) begin
        errs++; $display("FAIL b2b_decode got %h %h want 00 ff", by1, by2);
      end
      vecs++;
      for (int i = s2 + 10 * CPB; i < q.size(); i++)
        if (q[i] !== 1'b1) begin
          errs++; $display("FAIL b2b_no_third_frame cycle=%0d got %b want 1", i, q[i]);
          break;
        end
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_while_busy();
    int bad;
    bad = 0;
    test_frame(8'($urandom), 1'b0, 30, "ignore_while_busy");
    repeat (150) begin
      @(negedge clk);
      if (d1 !== 1'b1 || b1 !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++; $display("FAIL ignore_no_extra_frame got %0d non-idle cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    din = 8'h00; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    repeat (36) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (d1 !== 1'b1 || b1 !== 1'b0 || r1 !== 1'b0) begin
      errs++; $display("FAIL reset_mid_frame got d/b/r=%b%b%b want 100", d1, b1, r1);
    end
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (d1 !== 1'b1 || b1 !== 1'b0 || r1 !== 1'b1) begin
      errs++; $display("FAIL reset_mid_idle got d/b/r=%b%b%b want 101", d1, b1, r1);
    end
    test_frame(8'h81, 1'b0, -1, "after_reset_81");
  endtask

  task automatic test_random();
    repeat (6) test_frame(8'($urandom), 1'($urandom_range(0, 1)), -1, "random");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame(8'hA5, 1'b0, -1, "frame_a5");
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
    test_frame(8'h55, 1'b1, -1, "two_stop_55");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
